// File: rtl/falcon_modsub_stream.sv
// Streaming modular subtractor: out_c = (in_a - in_b) mod Q through a
// two-stage elastic pipeline, with vector-length counting, end-of-vector
// pulse and a sticky out-of-range operand flag.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; ready never depends on the valid of the same interface.
module falcon_modsub_stream #(
  parameter int Q = 12289,
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic         out_last,
  output logic         done,
  output logic [10:0]  vec_cnt,
  output logic         err
);

  localparam logic [W:0]   Q_EXT = (W+1)'(Q);
  localparam logic [W-1:0] Q_LOW = W'(Q);

  logic         s1_valid;
  logic [W:0]   s1_d;
  logic         s1_last;
  logic         s2_advance;
  logic         accept;
  logic         deliver;
  logic [W-1:0] s1_c;
  logic         op_bad;

  // Handshake decode and the S2 correction: a negative difference is lifted
  // by Q; only the low W bits are kept, so the arithmetic is modulo 2^W.
  always_comb begin
    s2_advance = !out_valid || out_ready;
    in_ready   = !clr && (!s1_valid || s2_advance);
    accept     = in_valid && in_ready;
    deliver    = out_valid && out_ready;
    s1_c       = s1_d[W] ? (s1_d[W-1:0] + Q_LOW) : s1_d[W-1:0];
    op_bad     = ({1'b0, in_a} >= Q_EXT) || ({1'b0, in_b} >= Q_EXT);
  end

  // Stage 1: capture the signed (W+1)-bit difference and the last marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_last  <= 1'b0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_d     <= {1'b0, in_a} - {1'b0, in_b};
      s1_last  <= in_last;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register; holds its contents while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_last  <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_last  <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_c    <= s1_c;
        out_last <= s1_last;
      end
    end
  end

  // Delivery bookkeeping: per-vector count, end-of-vector pulse, sticky err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      vec_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= deliver && out_last;
      if (deliver) begin
        vec_cnt <= out_last ? 11'd0 : vec_cnt + 11'd1;
      end
      if (accept && op_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_falcon_modsub_stream.sv
// Bench for falcon_modsub_stream: directed vectors with hand-computed results,
// a scoreboard on every delivery, and a randomized valid/ready soak.
module tb_falcon_modsub_stream;

  localparam int Q = 12289;
  localparam int W = 14;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic         out_last;
  logic         done;
  logic [10:0]  vec_cnt;
  logic         err;

  falcon_modsub_stream #(.Q(Q), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_c    (out_c),
    .out_last (out_last),
    .done     (done),
    .vec_cnt  (vec_cnt),
    .err      (err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int n_done   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = d + Q;
    return W'(d);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: record accepted pairs, compare every delivered result in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b));
        exp_last_q.push_back(in_last);
      end
      if (out_valid && out_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("sb_data", out_c, exp_q.pop_front());
          check("sb_last", out_last, exp_last_q.pop_front());
        end
      end
      if (done) n_done++;
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic acc;
  int k, sent, oi, after, fin, last_seen, d0, done0;
  int pa[4] = '{100, 40, 7, 1};
  int pb[4] = '{40, 100, 7, 12288};
  int ph[4] = '{60, 12229, 0, 2};

  task automatic set_vec(input int i);
    in_a    = W'((i * 37) % Q);
    in_b    = W'((i * 101) % Q);
    in_last = (i == 511);
  endtask

  initial begin
    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_last = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_c", out_c, 0);
    check("rst_vec_cnt", vec_cnt, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_idle_valid", out_valid, 0);

    // streamed pairs, full flow
    tick(); out_ready = 1'b1; in_valid = 1'b1; in_a = 14'd5; in_b = 14'd3;
    @(negedge clk); check("flow_in_ready", in_ready, 1);
    tick(); in_a = 14'd3; in_b = 14'd5;
    @(negedge clk); check("flow_lat_not_yet", out_valid, 0);
    tick(); in_a = 14'd0; in_b = 14'd12288;
    @(negedge clk); check("flow_v0", out_valid, 1); check("flow_c0", out_c, 2);
    tick(); in_a = 14'd12288; in_b = 14'd0;
    @(negedge clk); check("flow_c1", out_c, 12287);
    tick(); in_valid = 1'b0;
    @(negedge clk); check("flow_c2", out_c, 1);
    tick();
    @(negedge clk); check("flow_c3", out_c, 12288); check("flow_v3", out_valid, 1);
    tick();
    @(negedge clk); check("flow_drained", out_valid, 0);

    // backpressure: 4 pairs while out_ready low for 5 cycles
    tick(); out_ready = 1'b0; k = 0; oi = 0; d0 = n_deliv;
    in_valid = 1'b1; in_a = W'(pa[0]); in_b = W'(pb[0]);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (cyc == 2) check("stall_in_ready", in_ready, 0);
      if (cyc >= 2 && cyc <= 4) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_c", out_c, 60);
      end
      if (out_valid && out_ready) begin
        if (oi < 4) check("stall_order", out_c, ph[oi]);
        else check("stall_extra", oi, 3);
        oi++;
      end
      tick();
      if (acc) begin
        k++;
        if (k < 4) begin in_a = W'(pa[k]); in_b = W'(pb[k]); end
        else in_valid = 1'b0;
      end
      if (cyc == 4) out_ready = 1'b1;
    end
    check("stall_count", n_deliv - d0, 4);
    check("cnt_after_8", vec_cnt, 8);

    // clear before the long vector
    clr = 1'b1; tick(); clr = 1'b0;
    @(negedge clk); check("clr_vec_cnt", vec_cnt, 0);

    // 512-pair vector with last on the final pair
    tick(); k = 0; after = 0; fin = 0; last_seen = 0; done0 = n_done;
    in_valid = 1'b1; set_vec(0);
    for (int cyc = 0; cyc < 800 && fin == 0; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready && out_last) begin
        check("vec_cnt_before_last", vec_cnt, 511);
        last_seen++;
        after = 1;
      end else if (after == 1) begin
        check("vec_cnt_wrap_zero", vec_cnt, 0);
        check("vec_done_pulse", done, 1);
        after = 2;
      end else if (after == 2) begin
        check("vec_done_single", done, 0);
        fin = 1;
      end
      tick();
      if (acc) begin
        k++;
        if (k < 512) set_vec(k);
        else begin in_valid = 1'b0; in_last = 1'b0; end
      end
    end
    check("vec_finished", fin, 1);
    check("vec_last_count", last_seen, 1);
    check("vec_done_count", n_done - done0, 1);

    // out-of-range operand sets sticky err
    in_valid = 1'b1; in_a = 14'd12289; in_b = 14'd1; in_last = 1'b0;
    @(negedge clk); check("err_acc", in_ready, 1);
    tick(); in_a = 14'd10; in_b = 14'd3;
    @(negedge clk); check("err_set", err, 1);
    tick(); in_valid = 1'b0;
    @(negedge clk); check("err_bad_result", out_c, 12288);
    tick();
    @(negedge clk); check("err_legal_result", out_c, 7);
    repeat (3) tick();
    @(negedge clk); check("err_sticky", err, 1); check("err_vec_cnt", vec_cnt, 2);
    tick(); clr = 1'b1; in_valid = 1'b1; in_a = 14'd9; in_b = 14'd1;
    @(negedge clk); check("clr_in_ready", in_ready, 0);
    tick(); clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_err", err, 0); check("clr_cnt", vec_cnt, 0); check("clr_valid", out_valid, 0);
    tick();
    @(negedge clk); check("clr_discard", out_valid, 0);

    // reset with both stages full
    tick(); out_ready = 1'b0; in_valid = 1'b1; in_a = 14'd20; in_b = 14'd5;
    @(negedge clk);
    tick(); in_a = 14'd5; in_b = 14'd20;
    @(negedge clk);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    check("full_out_c", out_c, 15);
    #2 rst_n = 1'b0;
    exp_q.delete(); exp_last_q.delete();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_c", out_c, 0);
    check("arst_out_last", out_last, 0);
    check("arst_vec_cnt", vec_cnt, 0);
    check("arst_done", done, 0);
    tick(); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk); check("arst_in_ready", in_ready, 1);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); check("arst_no_stale", out_valid, 0);
    end

    // random valid/ready soak
    tick(); sent = 0; d0 = n_deliv; in_valid = 1'b0; in_last = 1'b0;
    for (int cyc = 0; cyc < 4000 && (sent < 200 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      if (acc || !in_valid) begin
        if (sent < 200 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_a = W'($urandom_range(0, Q - 1));
          in_b = W'($urandom_range(0, Q - 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = (sent >= 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    check("rand_sent", sent, 200);
    check("rand_delivered", n_deliv - d0, 200);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
